// File: rtl/load_store_unit.sv
// MEM-stage sequencer: splits RV32 loads/stores into byte accesses on an 8-bit memory, little-endian.
// Byte i is driven in cycle i+1 after accept, done pulses in cycle N+1; stall_o holds the pipeline until then.
module load_store_unit #(
  parameter int ADDR_W           = 8,
  parameter int XLEN             = 32,
  parameter bit ALLOW_MISALIGNED = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              is_store_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [XLEN-1:0]   wdata_i,
  output logic              stall_o,
  output logic              done_o,
  output logic [XLEN-1:0]   rdata_o,
  output logic              err_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_wdata_o,
  input  logic [7:0]        mem_rdata_i
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                is_store_q, is_store_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]     wdata_q, wdata_d;
  logic [XLEN-1:0]     asm_q, asm_d;
  logic [XLEN-1:0]     rdata_q, rdata_d;
  logic                err_q, err_d;

  logic                req_illegal;
  logic                req_misaligned;
  logic [1:0]          last_cnt;

  function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] w, input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return {{(XLEN-8){~f3[2] & w[7]}}, w[7:0]};
      2'd1:    return {{(XLEN-16){~f3[2] & w[15]}}, w[15:0]};
      default: return w;
    endcase
  endfunction

  // Size 3 is never legal; stores have no unsigned form; loads have no unsigned word.
  assign req_illegal = (funct3_i[1:0] == 2'd3)
                     || (is_store_i && funct3_i[2])
                     || (!is_store_i && funct3_i[2] && (funct3_i[1:0] == 2'd2));

  assign req_misaligned = ((funct3_i[1:0] == 2'd1) && addr_i[0])
                        || ((funct3_i[1:0] == 2'd2) && (addr_i[1:0] != 2'd0));

  assign last_cnt = (funct3_q[1:0] == 2'd2) ? 2'd3 : {1'b0, funct3_q[0]};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_store_d  = is_store_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    asm_d       = asm_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    req_ready_o = 1'b0;
    done_o      = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;

    case (state_q)
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          is_store_d = is_store_i;
          funct3_d   = funct3_i;
          addr_d     = addr_i;
          wdata_d    = wdata_i;
          asm_d      = '0;
          rdata_d    = '0;
          err_d      = 1'b0;
          cnt_d      = 2'd0;
          if (req_illegal || (req_misaligned && !ALLOW_MISALIGNED)) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            state_d = S_ACCESS;
          end
        end
      end

      S_ACCESS: begin
        mem_addr_o = addr_q + ADDR_W'(cnt_q);
        if (is_store_q) begin
          mem_we_o    = 1'b1;
          mem_wdata_o = wdata_q[{cnt_q, 3'b000} +: 8];
        end else begin
          asm_d[{cnt_q, 3'b000} +: 8] = mem_rdata_i;
        end
        if (cnt_q == last_cnt) begin
          state_d = S_DONE;
          rdata_d = is_store_q ? '0 : load_ext(asm_d, funct3_q);
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end

      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      cnt_q      <= 2'd0;
      is_store_q <= 1'b0;
      funct3_q   <= 3'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      asm_q      <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_store_q <= is_store_d;
      funct3_q   <= funct3_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      asm_q      <= asm_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  assign stall_o = ~req_ready_o;
  assign rdata_o = rdata_q;
  assign err_o   = err_q;

endmodule
